uart_tx_scheduler: RTL and testbench

//   Shares the single uart_tx transmitter between NUM_REQ response sources:

---
 rtl/uart_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Arbitrates NUM_REQ message sources onto one uart_tx: latches the winning
// message, then hands it out byte by byte over the valid/busy handshake.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BYTES    = 2,
  parameter int PRIO0        = 1,
  parameter int BUSY_TIMEOUT = 8,
  localparam int LEN_W = $clog2(MAX_BYTES + 1),
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PW    = MAX_BYTES * 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*PW-1:0]    req_payload,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     done,
  output logic [ID_W-1:0]          active_id,
  output logic                     sched_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_busy
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_done;
  logic [ID_W-1:0]    r_active_id;
  logic               r_sched_busy;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [LEN_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_len_m1;
  logic [PW-1:0]      r_payload;
  logic [CNT_W-1:0]   r_cnt;

  logic [LEN_W-1:0]   w_len_arr [NUM_REQ];
  logic [PW-1:0]      w_pay_arr [NUM_REQ];
  logic [7:0]         w_byte_arr [MAX_BYTES];
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_cand;
  logic               w_found;
  logic [LEN_W-1:0]   w_win_len;
  logic [LEN_W-1:0]   w_len_m1;
  logic [7:0]         w_cur_byte;
  logic [ID_W-1:0]    w_rr_next;
  logic               w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_slice
      assign w_len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
      assign w_pay_arr[gi] = req_payload[gi*PW +: PW];
    end
    // Byte 0 is the most significant byte of the latched payload.
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_byte_slice
      assign w_byte_arr[gi] = r_payload[(MAX_BYTES-gi)*8-1 -: 8];
    end
  endgenerate

  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
    if (PRIO0 != 0 && req[0]) w_win = '0;
  end

  assign w_win_len = w_len_arr[w_win];

  always_comb begin
    if (w_win_len == '0)
      w_len_m1 = '0;
    else if (w_win_len > LEN_W'(MAX_BYTES))
      w_len_m1 = LEN_W'(MAX_BYTES - 1);
    else
      w_len_m1 = w_win_len - LEN_W'(1);
  end

  always_comb begin
    w_cur_byte = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (r_idx == LEN_W'(i)) w_cur_byte = w_byte_arr[i];
    end
  end

  assign w_rr_next = (r_active_id == ID_W'(NUM_REQ - 1)) ? '0 : r_active_id + ID_W'(1);
  // Counter reaches BUSY_TIMEOUT on the cycle it would increment past BUSY_TIMEOUT-1.
  assign w_timeout = (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_done       <= 1'b0;
      r_active_id  <= '0;
      r_sched_busy <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_rr_ptr     <= '0;
      r_idx        <= '0;
      r_len_m1     <= '0;
      r_payload    <= '0;
      r_cnt        <= '0;
    end else begin
      r_grant    <= '0;
      r_done     <= 1'b0;
      r_tx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_payload    <= w_pay_arr[w_win];
            r_len_m1     <= w_len_m1;
            r_active_id  <= w_win;
            r_idx        <= '0;
            r_grant      <= NUM_REQ'(1) << w_win;
            r_sched_busy <= 1'b1;
            r_state      <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            r_tx_data  <= w_cur_byte;
            r_tx_valid <= 1'b1;
            r_cnt      <= '0;
            r_state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy || w_timeout) begin
            if (r_idx == r_len_m1) begin
              r_done       <= 1'b1;
              r_rr_ptr     <= w_rr_next;
              r_sched_busy <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_idx   <= r_idx + LEN_W'(1);
              r_state <= SEND;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_sched_busy <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign active_id  = r_active_id;
  assign sched_busy = r_sched_busy;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a priority instance (a) and a round-robin
// instance (b), each with a small uart_tx busy model, checked per transaction.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [7:0]  req_len;
  logic [63:0] req_payload;

  logic [3:0] grant_a, grant_b;
  logic       done_a, done_b;
  logic [1:0] active_id_a, active_id_b;
  logic       sched_busy_a, sched_busy_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_busy_a, tx_busy_b;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .MAX_BYTES(2), .PRIO0(1), .BUSY_TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_len(req_len), .req_payload(req_payload),
    .grant(grant_a), .done(done_a), .active_id(active_id_a), .sched_busy(sched_busy_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_busy(tx_busy_a));

  uart_tx_scheduler #(.NUM_REQ(4), .MAX_BYTES(2), .PRIO0(0), .BUSY_TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_len(req_len), .req_payload(req_payload),
    .grant(grant_b), .done(done_b), .active_id(active_id_b), .sched_busy(sched_busy_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_busy(tx_busy_b));

  // uart_tx model: busy for 4 cycles starting the cycle after a strobe.
  logic [2:0] a_cnt, b_cnt;
  bit         a_stuck;
  always @(posedge clk) begin
    if (rst) a_cnt <= 3'd0;
    else if (tx_valid_a && !a_stuck) a_cnt <= 3'd4;
    else if (a_cnt != 3'd0) a_cnt <= a_cnt - 3'd1;
    if (rst) b_cnt <= 3'd0;
    else if (tx_valid_b) b_cnt <= 3'd4;
    else if (b_cnt != 3'd0) b_cnt <= b_cnt - 3'd1;
  end
  assign tx_busy_a = (a_cnt != 3'd0);
  assign tx_busy_b = (b_cnt != 3'd0);

  int         cyc;
  int         n_vec, n_err;
  bit         viol, drop_a, drop_b;
  int         a_gid[$], a_gcyc[$], a_aid[$], a_dcyc[$], a_bcyc[$];
  logic [7:0] a_b[$];
  int         b_gid[$], b_gcyc[$], b_dcyc[$];

  typedef struct {
    int          id;
    logic [1:0]  len;
    logic [15:0] pay;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t tbl[5];

  function automatic int oh_idx(input logic [3:0] g);
    int r = -1;
    int c = 0;
    for (int i = 0; i < 4; i++) if (g[i]) begin r = i; c++; end
    if (c != 1) r = -1;
    return r;
  endfunction

  function automatic int qa(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if ((tx_valid_a && tx_busy_a) || (tx_valid_b && tx_busy_b)) viol = 1'b1;
    if (grant_a != 4'd0) begin
      a_gid.push_back(oh_idx(grant_a));
      a_gcyc.push_back(cyc);
      a_aid.push_back(int'(active_id_a));
      if (drop_a) req_a = req_a & ~grant_a;
    end
    if (done_a) a_dcyc.push_back(cyc);
    if (tx_valid_a) begin
      a_b.push_back(tx_data_a);
      a_bcyc.push_back(cyc);
    end
    if (grant_b != 4'd0) begin
      b_gid.push_back(oh_idx(grant_b));
      b_gcyc.push_back(cyc);
      if (drop_b) req_b = req_b & ~grant_b;
    end
    if (done_b) b_dcyc.push_back(cyc);
  endtask

  task automatic clear_logs();
    a_gid.delete(); a_gcyc.delete(); a_aid.delete(); a_dcyc.delete();
    a_bcyc.delete(); a_b.delete();
    b_gid.delete(); b_gcyc.delete(); b_dcyc.delete();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 4'd0;
    req_b = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_slot(input int id, input logic [1:0] len, input logic [15:0] pay);
    req_len[id*2 +: 2]      = len;
    req_payload[id*16 +: 16] = pay;
  endtask

  initial begin
    int start, t1, t2;
    n_vec = 0; n_err = 0; cyc = 0; viol = 1'b0;
    drop_a = 1'b1; drop_b = 1'b1; a_stuck = 1'b0;
    req_len = 8'd0; req_payload = 64'd0;
    tbl[0] = '{id: 2, len: 2'd1, pay: 16'h55AA, nb: 1, b0: 8'h55, b1: 8'h00};
    tbl[1] = '{id: 0, len: 2'd2, pay: 16'hA1C4, nb: 2, b0: 8'hA1, b1: 8'hC4};
    tbl[2] = '{id: 1, len: 2'd0, pay: 16'h3CF0, nb: 1, b0: 8'h3C, b1: 8'h00};
    tbl[3] = '{id: 3, len: 2'd3, pay: 16'h9E71, nb: 2, b0: 8'h9E, b1: 8'h71};
    tbl[4] = '{id: 3, len: 2'd2, pay: 16'hFF01, nb: 2, b0: 8'hFF, b1: 8'h01};

    do_reset();
    chk("reset_outs_a", {18'd0, grant_a, done_a, tx_valid_a, tx_data_a, active_id_a, sched_busy_a}, 32'd0);
    chk("reset_outs_b", {18'd0, grant_b, done_b, tx_valid_b, tx_data_b, active_id_b, sched_busy_b}, 32'd0);

    // Single-message vectors on the priority instance.
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      req_payload = {$urandom, $urandom};
      req_len     = 8'($urandom);
      set_slot(tbl[v].id, tbl[v].len, tbl[v].pay);
      req_a[tbl[v].id] = 1'b1;
      start = cyc;
      tick();
      chk($sformatf("v%0d_grant", v), {28'd0, grant_a}, 32'd1 << tbl[v].id);
      chk($sformatf("v%0d_sched_busy", v), {31'd0, sched_busy_a}, 32'd1);
      req_payload = ~req_payload;
      req_len     = ~req_len;
      for (int k = 0; k < 100 && a_dcyc.size() == 0; k++) tick();
      tick(); tick();
      $display("vector %0d: req %0d len %0d payload %h -> %0d bytes", v, tbl[v].id, tbl[v].len, tbl[v].pay, a_b.size());
      chk($sformatf("v%0d_grant_cnt", v), a_gid.size(), 1);
      chk($sformatf("v%0d_grant_lat", v), qa(a_gcyc, 0), start + 1);
      chk($sformatf("v%0d_active_id", v), qa(a_aid, 0), tbl[v].id);
      chk($sformatf("v%0d_nbytes", v), a_b.size(), tbl[v].nb);
      chk($sformatf("v%0d_byte0", v), (a_b.size() > 0) ? {24'd0, a_b[0]} : 32'hFFFF_FFFF, {24'd0, tbl[v].b0});
      chk($sformatf("v%0d_valid_lat", v), qa(a_bcyc, 0), qa(a_gcyc, 0) + 1);
      if (tbl[v].nb == 2) begin
        chk($sformatf("v%0d_byte1", v), (a_b.size() > 1) ? {24'd0, a_b[1]} : 32'hFFFF_FFFF, {24'd0, tbl[v].b1});
        chk($sformatf("v%0d_byte_gap", v), qa(a_bcyc, 1) - qa(a_bcyc, 0), 6);
      end
      chk($sformatf("v%0d_done_cnt", v), a_dcyc.size(), 1);
      chk($sformatf("v%0d_done_lat", v), qa(a_dcyc, 0), qa(a_bcyc, tbl[v].nb - 1) + 2);
      chk($sformatf("v%0d_idle", v), {31'd0, sched_busy_a}, 32'd0);
    end

    // Round-robin with 1110 held on the PRIO0=0 instance.
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) set_slot(i, 2'd1, 16'h1100 + 16'(i << 8));
    drop_b = 1'b0;
    req_b  = 4'b1110;
    for (int k = 0; k < 200 && b_gid.size() < 4; k++) tick();
    req_b = 4'd0;
    for (int k = 0; k < 50 && b_dcyc.size() < 4; k++) tick();
    drop_b = 1'b1;
    $display("round-robin: grants %0d %0d %0d %0d", qa(b_gid, 0), qa(b_gid, 1), qa(b_gid, 2), qa(b_gid, 3));
    chk("rr_g0", qa(b_gid, 0), 1);
    chk("rr_g1", qa(b_gid, 1), 2);
    chk("rr_g2", qa(b_gid, 2), 3);
    chk("rr_g3", qa(b_gid, 3), 1);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rr_gap%0d", k), qa(b_gcyc, k + 1), qa(b_dcyc, k) + 1);

    // Priority vs round-robin with rr_ptr=3 and requesters 0 and 3 pending.
    do_reset();
    clear_logs();
    req_a = 4'b0100;
    req_b = 4'b0100;
    for (int k = 0; k < 100 && (a_dcyc.size() < 1 || b_dcyc.size() < 1); k++) tick();
    clear_logs();
    req_a = 4'b1001;
    req_b = 4'b1001;
    for (int k = 0; k < 200 && (a_dcyc.size() < 2 || b_dcyc.size() < 2); k++) tick();
    $display("priority: prio order %0d %0d, rr order %0d %0d", qa(a_gid, 0), qa(a_gid, 1), qa(b_gid, 0), qa(b_gid, 1));
    chk("prio_first", qa(a_gid, 0), 0);
    chk("prio_second", qa(a_gid, 1), 3);
    chk("rrmode_first", qa(b_gid, 0), 3);
    chk("rrmode_second", qa(b_gid, 1), 0);

    // Timeout: uart model never raises busy.
    do_reset();
    clear_logs();
    a_stuck = 1'b1;
    set_slot(1, 2'd2, 16'h1234);
    req_a = 4'b0010;
    for (int k = 0; k < 100 && a_dcyc.size() == 0; k++) tick();
    tick();
    a_stuck = 1'b0;
    t1 = qa(a_bcyc, 0);
    t2 = qa(a_bcyc, 1);
    $display("timeout: bytes at cycles %0d and %0d, done at %0d", t1, t2, qa(a_dcyc, 0));
    chk("to_nbytes", a_b.size(), 2);
    chk("to_byte1", (a_b.size() > 1) ? {24'd0, a_b[1]} : 32'hFFFF_FFFF, 32'h34);
    chk("to_gap", t2 - t1, 9);
    chk("to_done_cnt", a_dcyc.size(), 1);
    chk("to_done_lat", qa(a_dcyc, 0), t2 + 8);

    // Reset after the first byte of a two-byte message.
    do_reset();
    clear_logs();
    set_slot(3, 2'd2, 16'hBEEF);
    set_slot(1, 2'd1, 16'h7700);
    req_a = 4'b1000;
    for (int k = 0; k < 20 && a_b.size() == 0; k++) tick();
    chk("mid_first_byte", (a_b.size() > 0) ? {24'd0, a_b[0]} : 32'hFFFF_FFFF, 32'hBE);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", {18'd0, grant_a, done_a, tx_valid_a, tx_data_a, active_id_a, sched_busy_a}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("mid_no_done", a_dcyc.size(), 0);
    chk("mid_one_byte", a_b.size(), 1);
    clear_logs();
    req_a = 4'b1010;
    start = cyc;
    for (int k = 0; k < 100 && a_dcyc.size() < 2; k++) tick();
    $display("after reset: grants %0d %0d", qa(a_gid, 0), qa(a_gid, 1));
    chk("post_rst_g0", qa(a_gid, 0), 1);
    chk("post_rst_lat", qa(a_gcyc, 0), start + 1);
    chk("post_rst_g1", qa(a_gid, 1), 3);

    chk("valid_while_busy", {31'd0, viol}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
